// File: rtl/key_step_counter.sv
// key_step_counter: two raw active-low push-buttons (up/down) are synchronized,
// debounced and turned into single step pulses that move a wrapping 4-bit
// count. A parallel load overrides stepping. `changed` pulses for one cycle
// whenever the visible count takes a new value.
//
// Optional build macro KEY_AUTO_REPEAT_EN: when defined, a key held in the
// debounced HELD state issues extra steps, the first REPEAT_DELAY cycles after
// acceptance and then one every REPEAT_PERIOD cycles. When undefined no repeat
// timers exist and every debounced press yields exactly one step.

module key_step_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic step
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  // Parameter sanity: the debounce FSM needs at least two samples, and the
  // repeat timers need non-zero intervals.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
    $error("key_step_debounce: DEBOUNCE_CYCLES must be >= 2, repeat intervals >= 1");
  end

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    DISARMING = 2'd3
  } state_t;

  logic             sync_p0;
  logic             sync_p1;
  logic             pressed;
  state_t           state;
  logic [CNT_W-1:0] cnt;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_tmr;
  logic             rep_first;
`endif

  // Stage p0/p1: two-flop synchronizer; reset forces the "released" level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed = ~sync_p1;

  // Stage p2: debounce FSM; step is a registered one-cycle pulse issued on
  // the ARMING->HELD transition (and on repeat expiry when enabled).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= CNT_ZERO;
      step  <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      rep_tmr   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      step <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      // Timer is idle outside HELD; the HELD branch overrides this.
      rep_tmr   <= '0;
      rep_first <= 1'b1;
`endif
      case (state)
        RELEASED: begin
          if (pressed) begin
            state <= ARMING;
            cnt   <= CNT_ONE;
          end
        end
        ARMING: begin
          if (!pressed) begin
            state <= RELEASED;
            cnt   <= CNT_ZERO;
          end else if (cnt == CNT_MAX) begin
            state <= HELD;
            cnt   <= CNT_ZERO;
            step  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!pressed) begin
            state <= DISARMING;
            cnt   <= CNT_ONE;
          end
`ifdef KEY_AUTO_REPEAT_EN
          else if (rep_tmr == (rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
            step      <= 1'b1;
            rep_tmr   <= '0;
            rep_first <= 1'b0;
          end else begin
            rep_tmr   <= rep_tmr + REP_W'(1);
            rep_first <= rep_first;
          end
`endif
        end
        DISARMING: begin
          if (pressed) begin
            // Release bounce: back to HELD without a new step.
            state <= HELD;
            cnt   <= CNT_ZERO;
          end else if (cnt == CNT_MAX) begin
            state <= RELEASED;
            cnt   <= CNT_ZERO;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

module key_step_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] count,
  output logic       changed
);

  logic       step_up_p2;
  logic       step_down_p2;
  logic [3:0] count_nxt;

  // Count update priority: load, then cancelling steps, then up, then down.
  // A step that coincides with load is dropped. Arithmetic wraps mod 16.
  function automatic logic [3:0] next_count(
    input logic [3:0] cur,
    input logic       ld,
    input logic [3:0] ld_val,
    input logic       up,
    input logic       dn
  );
    logic [3:0] nxt;
    nxt = cur;
    if (ld) begin
      nxt = ld_val;
    end else if (up && dn) begin
      nxt = cur;
    end else if (up) begin
      nxt = cur + 4'd1;
    end else if (dn) begin
      nxt = cur - 4'd1;
    end
    return nxt;
  endfunction

  key_step_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_up (
    .clk   (CLOCK_50),
    .rst   (reset),
    .key_n (key_up_n),
    .step  (step_up_p2)
  );

  key_step_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_down (
    .clk   (CLOCK_50),
    .rst   (reset),
    .key_n (key_down_n),
    .step  (step_down_p2)
  );

  // Next count value from load and the step pulses.
  always_comb begin
    count_nxt = next_count(count, load, load_value, step_up_p2, step_down_p2);
  end

  // Stage p3: count register; changed flags the first cycle of a new value.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count   <= 4'd0;
      changed <= 1'b0;
    end else begin
      count   <= count_nxt;
      changed <= (count_nxt != count);
    end
  end

endmodule
